// File: rtl/alu_regfile_wb.sv
// ---------------------------------------------------------------------------
// alu_regfile_wb
//   Architectural register file and write-back stage around the ALU of the
//   single-cycle CPU. Two combinational read ports feed the ALU operands; the
//   ALU result is committed to the destination register on the next rising
//   edge. A registered copy of the ALU flag is kept for the branch logic, and
//   a sticky tracker records write-back attempts with an illegal opcode.
//
//   Ports
//     clk, rst             clock; asynchronous active-high reset
//     rs1_addr, rs2_addr   read addresses
//     rs1_data, rs2_data   read data (combinational, no write bypass)
//     wr_en, rd_addr       write-back enable and destination register
//     alu_opcode           opcode presented to the ALU this cycle
//     alu_result           value to commit
//     alu_flag             ALU flag output
//     clr_illegal          synchronous clear of illegal_op
//     flag_q               registered ALU flag
//     illegal_op           sticky illegal write-back indicator (tracker state)
// ---------------------------------------------------------------------------
module alu_regfile_wb #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [4:0]        alu_opcode,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_flag,
    input  logic              clr_illegal,
    output logic              flag_q,
    output logic              illegal_op
);

    localparam logic [4:0] OP_MAX = 5'b01110;

    // Illegal-op tracker. illegal_op is the direct decode of this state, so
    // the state is observable at the port without an extra debug output.
    typedef enum logic {
        CLEAN = 1'b0,
        WRAP  = 1'b1
    } ill_state_t;

    ill_state_t state, state_next;

    logic [WIDTH-1:0] regs [DEPTH];

    logic legal;
    logic commit;
    logic flag_op;
    logic flag_upd;

    assign legal  = (alu_opcode <= OP_MAX);
    // alu_result is only sampled when commit is set, so the ALU's hi-Z
    // default result never reaches the array.
    assign commit = wr_en & legal & (rd_addr != '0);

    // Only these opcodes drive alu_flag; other opcodes leave it undefined.
    assign flag_op  = (alu_opcode == 5'b00000) | (alu_opcode == 5'b01000) |
                      (alu_opcode == 5'b01011) | (alu_opcode == 5'b01100);
    assign flag_upd = wr_en & flag_op;

    // Reads deliberately have no write bypass: bypassing would close the
    // combinational loop rs -> ALU -> result -> rs.
    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            flag_q <= 1'b0;
        end else begin
            if (commit) begin
                regs[rd_addr] <= alu_result;
            end
            if (flag_upd) begin
                flag_q <= alu_flag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAN;
        end else begin
            state <= state_next;
        end
    end

    // A new illegal write on the same edge as clr_illegal keeps WRAP.
    always_comb begin
        state_next = state;
        illegal_op = (state == WRAP);
        case (state)
            CLEAN: if (wr_en && !legal) state_next = WRAP;
            WRAP:  if (!(wr_en && !legal) && clr_illegal) state_next = CLEAN;
            default: state_next = CLEAN;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile_wb.sv
module tb_alu_regfile_wb;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0, alu_opcode = '0;
  logic [31:0] rs1_data, rs2_data, alu_result = '0;
  logic        wr_en = 1'b0, alu_flag = 1'b0, clr_illegal = 1'b0;
  logic        flag_q, illegal_op;

  always #5 clk = ~clk;

  alu_regfile_wb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .rd_addr(rd_addr),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_flag(alu_flag),
    .clr_illegal(clr_illegal),
    .flag_q(flag_q), .illegal_op(illegal_op)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic        m_flag;
  logic        m_ill;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_flag = 1'b0;
    m_ill  = 1'b0;
  endtask

  // Applies the architectural rules to whatever the bench is driving now.
  task automatic model_edge();
    int op;
    op = alu_opcode;
    if (wr_en && op <= 14 && rd_addr != 0) m_regs[rd_addr] = alu_result;
    if (wr_en && (op == 0 || op == 8 || op == 11 || op == 12)) m_flag = alu_flag;
    if (wr_en && op > 14) m_ill = 1'b1;
    else if (clr_illegal) m_ill = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wr, input logic [4:0] rd, input logic [4:0] op,
                       input logic [31:0] res, input logic fl, input logic clr,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    wr_en = wr; rd_addr = rd; alu_opcode = op; alu_result = res;
    alu_flag = fl; clr_illegal = clr; rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b0; clr_illegal = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [4:0]  op;
    logic [31:0] res;
    logic        fl;
    logic        clr;
    logic [4:0]  rs;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
    logic        exp_flag;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [12];

  initial begin
    model_reset();

    vecs[0]  = '{1'b1, 5'd5, 5'b00000, 32'hDEADBEEF, 1'b0, 1'b0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd0, 5'b00000, 32'h00001234, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd7, 5'b01011, 32'h00000001, 1'b1, 1'b0, 5'd7, 32'h0,        32'h1,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd8, 5'b00100, 32'h00000055, 1'b0, 1'b0, 5'd8, 32'h0,        32'h55,       1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd3, 5'b10000, 32'h0000FFFF, 1'b0, 1'b0, 5'd3, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[5]  = '{1'b1, 5'd3, 5'b11111, 32'h0000FFFF, 1'b0, 1'b1, 5'd3, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[6]  = '{1'b0, 5'd3, 5'b00000, 32'h0000AAAA, 1'b0, 1'b1, 5'd3, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd4, 5'b10101, 32'h00000004, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd0, 5'b01000, 32'h00000099, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd5, 5'b01110, 32'hCAFEF00D, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd6, 5'b01111, 32'h00000001, 1'b0, 1'b0, 5'd6, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd6, 5'b00000, 32'h0,        1'b0, 1'b1, 5'd6, 32'h0,        32'h0,        1'b0, 1'b0};

    // T1: reset state, every address on both ports
    do_reset();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'(a), 5'(31 - a));
      check("reset_rs1", rs1_data, 32'h0);
      check("reset_rs2", rs2_data, 32'h0);
    end
    check("reset_flag", {31'b0, flag_q}, 32'h0);
    check("reset_ill", {31'b0, illegal_op}, 32'h0);

    // T2..T5 and opcode boundaries from the table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].op, vecs[i].res, vecs[i].fl,
            vecs[i].clr, vecs[i].rs, vecs[i].rs);
      check($sformatf("vec%0d_pre_rs1", i), rs1_data, vecs[i].exp_pre);
      check($sformatf("vec%0d_pre_rs2", i), rs2_data, vecs[i].exp_pre);
      tick();
      check($sformatf("vec%0d_post_rs1", i), rs1_data, vecs[i].exp_post);
      check($sformatf("vec%0d_flag", i), {31'b0, flag_q}, {31'b0, vecs[i].exp_flag});
      check($sformatf("vec%0d_ill", i), {31'b0, illegal_op}, {31'b0, vecs[i].exp_ill});
    end

    // T6: asynchronous reset between edges, with a write in flight
    drive(1'b1, 5'd9, 5'b00001, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd9, 5'd9);
    tick();
    check("t6_written", rs1_data, 32'hA5A5A5A5);
    drive(1'b1, 5'd9, 5'b00001, 32'h11111111, 1'b0, 1'b0, 5'd9, 5'd9);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_rs1", rs1_data, 32'h0);
    check("t6_async_rs2", rs2_data, 32'h0);
    @(posedge clk);
    #1;
    check("t6_held_rs1", rs1_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    #1;
    check("t6_after_rs1", rs1_data, 32'h0);
    check("t6_after_flag", {31'b0, flag_q}, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), op, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      exp_q.push_back(m_regs[rs1_addr]);
      exp_q.push_back(m_regs[rs2_addr]);
      check("rand_rs1", rs1_data, exp_q.pop_front());
      check("rand_rs2", rs2_data, exp_q.pop_front());
      tick();
      check("rand_flag", {31'b0, flag_q}, {31'b0, m_flag});
      check("rand_ill", {31'b0, illegal_op}, {31'b0, m_ill});
    end

    // Final sweep of every register through both ports
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'(a), 5'(a));
      check("sweep_rs1", rs1_data, m_regs[a]);
      check("sweep_rs2", rs2_data, m_regs[a]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
